control_nivel: RTL and testbench

//   Game/level controller that drives the vehicle-lane level interface (NV level bus + CN load strobe).

---
 rtl/control_nivel.sv | 129 ++++++++++++
 tb/tb_control_nivel.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_nivel.sv
// rtl/control_nivel.sv - level/lives/phase controller driving the vehicle-lane NV bus and CN load strobe
// Optional CNV_CONTINUE_EN: START from GAMEOVER keeps the current level.
module control_nivel #(
  parameter int                       DATAWIDTH_NVL   = 2,
  parameter logic [DATAWIDTH_NVL-1:0] NV_MAX          = 2'b11,
  parameter int                       DATAWIDTH_LIVES = 2,
  parameter int                       LIVES_INIT      = 3,
  parameter int                       HIT_HOLD        = 8
) (
  input  logic                       CNV_CLOCK,
  input  logic                       CNV_RESET,
  input  logic                       CNV_START_IN,
  input  logic                       CNV_GOAL_IN,
  input  logic                       CNV_COLLISION_IN,
  input  logic                       CNV_TICK_IN,
  output logic [DATAWIDTH_NVL-1:0]   CNV_NV_OUT,
  output logic                       CNV_CN_OUT,
  output logic                       CNV_FROG_RST_OUT,
  output logic [DATAWIDTH_LIVES-1:0] CNV_LIVES_OUT,
  output logic                       CNV_PLAYING_OUT,
  output logic                       CNV_GAMEOVER_OUT,
  output logic                       CNV_WIN_OUT
);

  localparam int CW = $clog2(HIT_HOLD + 1);
  localparam logic [DATAWIDTH_LIVES-1:0] LIVES_START = DATAWIDTH_LIVES'(LIVES_INIT);
  localparam logic [CW-1:0] HOLD_START = CW'(HIT_HOLD);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_HIT, S_GAMEOVER, S_WIN
  } state_t;

  state_t                     state, state_nx;
  logic [DATAWIDTH_NVL-1:0]   nv_q, nv_nx;
  logic [DATAWIDTH_LIVES-1:0] lives_q, lives_nx;
  logic [CW-1:0]              cnt_q, cnt_nx;
  logic                       cn_q, playing_q, gameover_q, win_q;

  always_comb begin
    state_nx = state;
    nv_nx    = nv_q;
    lives_nx = lives_q;
    cnt_nx   = cnt_q;
    case (state)
      S_IDLE, S_WIN: begin
        if (CNV_START_IN) begin
          state_nx = S_LOAD;
          nv_nx    = '0;
          lives_nx = LIVES_START;
        end
      end
      S_GAMEOVER: begin
        if (CNV_START_IN) begin
          state_nx = S_LOAD;
          lives_nx = LIVES_START;
`ifdef CNV_CONTINUE_EN
          nv_nx    = nv_q;
`else
          nv_nx    = '0;
`endif
        end
      end
      S_LOAD: state_nx = S_PLAY;
      S_PLAY: begin
        // collision outranks a goal arriving in the same cycle
        if (CNV_COLLISION_IN) begin
          if (lives_q > DATAWIDTH_LIVES'(1)) begin
            lives_nx = lives_q - DATAWIDTH_LIVES'(1);
            cnt_nx   = HOLD_START;
            state_nx = S_HIT;
          end else begin
            lives_nx = '0;
            state_nx = S_GAMEOVER;
          end
        end else if (CNV_GOAL_IN) begin
          if (nv_q == NV_MAX) begin
            state_nx = S_WIN;
          end else begin
            nv_nx    = nv_q + DATAWIDTH_NVL'(1);
            state_nx = S_LOAD;
          end
        end
      end
      S_HIT: begin
        if (CNV_TICK_IN) begin
          if (cnt_q <= CW'(1)) begin
            cnt_nx   = '0;
            state_nx = S_LOAD;
          end else begin
            cnt_nx   = cnt_q - CW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // CN follows the LOAD cycle so NV has already been stable for one cycle
  always_ff @(posedge CNV_CLOCK) begin
    if (CNV_RESET) begin
      state      <= S_IDLE;
      nv_q       <= '0;
      lives_q    <= LIVES_START;
      cnt_q      <= '0;
      cn_q       <= 1'b0;
      playing_q  <= 1'b0;
      gameover_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      nv_q       <= nv_nx;
      lives_q    <= lives_nx;
      cnt_q      <= cnt_nx;
      cn_q       <= (state == S_LOAD);
      playing_q  <= (state_nx == S_PLAY);
      gameover_q <= (state_nx == S_GAMEOVER);
      win_q      <= (state_nx == S_WIN);
    end
  end

  assign CNV_NV_OUT       = nv_q;
  assign CNV_CN_OUT       = cn_q;
  assign CNV_FROG_RST_OUT = cn_q;
  assign CNV_LIVES_OUT    = lives_q;
  assign CNV_PLAYING_OUT  = playing_q;
  assign CNV_GAMEOVER_OUT = gameover_q;
  assign CNV_WIN_OUT      = win_q;

endmodule

// File: tb/tb_control_nivel.sv
// tb/tb_control_nivel.sv - directed and randomized checks of control_nivel against a rule-level model
module tb_control_nivel;
  logic       clk = 1'b0;
  logic       rst, start, goal, col, tick;
  logic [1:0] nv, lives;
  logic       cn, frog, playing, gameover, win;

  int errors = 0;
  int checks = 0;

  control_nivel dut (
    .CNV_CLOCK(clk), .CNV_RESET(rst), .CNV_START_IN(start), .CNV_GOAL_IN(goal),
    .CNV_COLLISION_IN(col), .CNV_TICK_IN(tick), .CNV_NV_OUT(nv), .CNV_CN_OUT(cn),
    .CNV_FROG_RST_OUT(frog), .CNV_LIVES_OUT(lives), .CNV_PLAYING_OUT(playing),
    .CNV_GAMEOVER_OUT(gameover), .CNV_WIN_OUT(win)
  );

  always #5 clk = ~clk;

  // model phases: 0 idle, 1 load, 2 play, 3 hit, 4 gameover, 5 win
  int m_phase = 0;
  int m_level = 0;
  int m_lives = 3;
  int m_hold  = 0;
  int m_cn    = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_level = 0; m_lives = 3; m_hold = 0; m_cn = 0;
      return;
    end
    m_cn = (m_phase == 1);
    if ((m_phase == 0 || m_phase == 5) && start) begin
      m_phase = 1; m_level = 0; m_lives = 3;
    end else if (m_phase == 4 && start) begin
      m_phase = 1; m_lives = 3;
`ifndef CNV_CONTINUE_EN
      m_level = 0;
`endif
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && col) begin
      if (m_lives > 1) begin
        m_lives--; m_hold = 8; m_phase = 3;
      end else begin
        m_lives = 0; m_phase = 4;
      end
    end else if (m_phase == 2 && goal) begin
      if (m_level == 3) m_phase = 5;
      else begin
        m_level++; m_phase = 1;
      end
    end else if (m_phase == 3 && tick) begin
      m_hold--;
      if (m_hold == 0) m_phase = 1;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic g, input logic c, input logic t);
    @(negedge clk);
    rst = r; start = s; goal = g; col = c; tick = t;
    @(posedge clk);
    #1;
    model_step();
    check("nv", int'(nv), m_level);
    check("cn", int'(cn), m_cn);
    check("frog_rst", int'(frog), m_cn);
    check("lives", int'(lives), m_lives);
    check("playing", int'(playing), int'(m_phase == 2));
    check("gameover", int'(gameover), int'(m_phase == 4));
    check("win", int'(win), int'(m_phase == 5));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; goal = 0; col = 0; tick = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_nv", int'(nv), 0);
    check("reset_lives", int'(lives), 3);
    check("reset_cn", int'(cn), 0);
    idle(2);

    // start, load, three level-ups, then a goal on the last level wins
    cyc(0, 1, 0, 0, 0);
    check("start_cn_not_yet", int'(cn), 0);
    idle(1);
    check("start_cn", int'(cn), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("goal_nv", int'(nv), i);
      idle(1);
      check("goal_cn", int'(cn), 1);
    end
    cyc(0, 0, 1, 0, 0);
    check("win_flag", int'(win), 1);
    idle(1);
    check("win_no_cn", int'(cn), 0);

    // hit hold: seven ticks no reload, eighth reloads at the same level
    cyc(0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0);
    check("hit_lives", int'(lives), 2);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    idle(1);
    check("hit_reload_cn", int'(cn), 1);
    check("hit_reload_nv", int'(nv), 0);

    // down to the last life, collision + goal together ends the game
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 1, 1, 0);
    check("over_flag", int'(gameover), 1);
    check("over_lives", int'(lives), 0);
    idle(1);
    check("over_no_cn", int'(cn), 0);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    check("restart_cn", int'(cn), 1);
    check("restart_lives", int'(lives), 3);

    // reset during the load cycle drops the pending strobe
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_load_cn", int'(cn), 0);
    check("rst_load_nv", int'(nv), 0);
    idle(1);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(199) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
          ($urandom_range(9) == 0), ($urandom_range(2) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
